// File: rtl/result_reader_pkg.sv
// Shared types and default sizing for the SRAM result read-back stage.
package result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Widths match the sram_wrapper port so the read path plugs in directly.
  localparam int          DEF_DATA_W     = 32;
  localparam int          DEF_ADDR_W     = 8;
  localparam logic [7:0]  DEF_BASE_ADDR  = 8'h00;
  localparam int          DEF_NUM_WORDS  = 16;
  localparam int          DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/result_reader_if.sv
// SRAM read port plus valid/ready result stream, grouped for the result reader.
interface result_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              cs_n;
  logic              we_n;
  logic [ADDR_W-1:0] address;
  logic              ry;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output cs_n, we_n, address, out_data, out_valid, out_last,
    input  ry, read_data, out_ready
  );

  modport slave (
    input  cs_n, we_n, address, out_data, out_valid, out_last,
    output ry, read_data, out_ready
  );
endinterface

// File: rtl/result_reader_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible while non-empty and reads as zero when empty.
module result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/result_reader.sv
// Reads NUM_WORDS result words back from SRAM one at a time and streams them out through a small FIFO.
// Defining RESULT_READER_CHECKSUM_EN adds a checksum output summing every word read in a run.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
  parameter int                NUM_WORDS  = DEF_NUM_WORDS,
  parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  result_reader_if.master  bus
`ifdef RESULT_READER_CHECKSUM_EN
  , output logic [DATA_W-1:0] checksum
`endif
);
  localparam int                CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   address_reg;
  logic [ADDR_W-1:0]   address_next;
  logic [CNT_W-1:0]    rd_cnt_reg;
  logic [CNT_W-1:0]    rd_cnt_next;
  logic                cs_n_next;
  logic                done_next;
  logic                push;
  logic                pop;
  logic                is_last;
  logic [DATA_W:0]     push_word;
  logic [DATA_W:0]     head_word;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign is_last   = (rd_cnt_reg == LAST_IDX);
  assign push_word = {is_last, bus.read_data};

  always_comb begin
    state_next   = state_reg;
    address_next = address_reg;
    rd_cnt_next  = rd_cnt_reg;
    cs_n_next    = 1'b1;
    done_next    = 1'b0;
    push         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          address_next = BASE_ADDR;
          rd_cnt_next  = '0;
          state_next   = REQ;
        end
      end
      REQ: begin
        // Only issue when the reply is guaranteed a FIFO slot.
        if (!fifo_full) begin
          cs_n_next  = 1'b0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.ry) begin
          push         = 1'b1;
          address_next = address_reg + 1'b1;
          rd_cnt_next  = rd_cnt_reg + 1'b1;
          state_next   = is_last ? DRAIN : REQ;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      address_reg <= BASE_ADDR;
      rd_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      address_reg <= address_next;
      rd_cnt_reg  <= rd_cnt_next;
    end
  end

  result_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = head_word[DATA_W-1:0];
  assign bus.out_last  = head_word[DATA_W];
  assign bus.cs_n      = cs_n_next;
  assign bus.we_n      = 1'b1;
  assign bus.address   = address_reg;
  assign done          = done_next;
  assign busy          = (state_reg != IDLE) && !done_next;

`ifdef RESULT_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      checksum_reg <= '0;
    end else if (push) begin
      checksum_reg <= checksum_reg + bus.read_data;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: table of run scenarios plus random runs against an SRAM/stream reference model.
module tb_result_reader;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NW    = 16;
  localparam int DEPTH = 4;
  localparam int QN    = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done;
  logic w_start, w_busy, w_done;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [DW-1:0] checksum, w_checksum;
`endif

  result_reader_if #(.DATA_W(DW), .ADDR_W(AW)) rr ();
  result_reader_if #(.DATA_W(DW), .ADDR_W(AW)) rw ();

  result_reader #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(8'h00), .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(rr)
`ifdef RESULT_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  result_reader #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(8'hFE), .NUM_WORDS(4), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .start(w_start), .busy(w_busy), .done(w_done), .bus(rw)
`ifdef RESULT_READER_CHECKSUM_EN
    , .checksum(w_checksum)
`endif
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference SRAM contents and configuration (written only by the stimulus process).
  logic [DW-1:0] sram [256];
  int lat_cfg = 1, ready_pct = 100, hold_until = 0, flush_gen = 0;
  bit noise_en = 1'b0;

  // Model/monitor state (written only by the negedge process).
  int cyc = 0, occ = 0, seen_gen = 0, pend_cnt = 0;
  int act_n = 0, req_n = 0, done_n = 0, last_hs_cyc = -100;
  int hold_err = 0, overlap_err = 0, we_err = 0, gap_err = 0, busy_err = 0, occ_over = 0;
  int pushes_now, pops_now;
  logic [AW-1:0] pend_addr;
  bit prev_cs_low = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic [DW-1:0] act_d [QN];
  logic          act_l [QN];
  logic [AW-1:0] req_a [QN];

  always @(negedge clk) begin
    cyc++;
    pushes_now = 0;
    pops_now   = 0;
    if (seen_gen != flush_gen) begin
      seen_gen    = flush_gen;
      occ         = 0;
      pend_cnt    = 0;
      prev_cs_low = 1'b0;
    end
    rr.out_ready = (cyc >= hold_until) && (int'($urandom_range(99)) < ready_pct);
    if (!rst && prev_stall &&
        (!rr.out_valid || rr.out_data !== prev_data || rr.out_last !== prev_last)) hold_err++;
    if (!rst && rr.out_valid && rr.out_ready) begin
      act_d[act_n % QN] = rr.out_data;
      act_l[act_n % QN] = rr.out_last;
      act_n++;
      last_hs_cyc = cyc;
      pops_now    = 1;
      $display("[TB] word %0d: data=0x%08h last=%0b", act_n, rr.out_data, rr.out_last);
    end
    prev_stall = !rst && rr.out_valid && !rr.out_ready;
    prev_data  = rr.out_data;
    prev_last  = rr.out_last;
    if (done) begin
      done_n++;
      if (cyc - last_hs_cyc != 1) gap_err++;
      if (busy) busy_err++;
    end
    // SRAM: one reply lat_cfg cycles after each select; optional stray ry while no read is in flight.
    rr.ry = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rr.ry        = 1'b1;
        rr.read_data = sram[pend_addr];
        pushes_now   = 1;
      end
    end
    if (rr.cs_n === 1'b0) begin
      if (rr.we_n !== 1'b1) we_err++;
      if (pend_cnt > 0 || prev_cs_low) overlap_err++;
      req_a[req_n % QN] = rr.address;
      req_n++;
      pend_cnt  = lat_cfg;
      pend_addr = rr.address;
    end else if (noise_en && !rr.ry && pend_cnt == 0 && $urandom_range(3) == 0) begin
      rr.ry        = 1'b1;
      rr.read_data = $urandom;
    end
    prev_cs_low = (rr.cs_n === 1'b0);
    occ = occ + pushes_now - pops_now;
    if (occ > DEPTH) occ_over++;
  end

  // Wrap-around instance: fixed one-cycle SRAM latency, always-ready consumer.
  int w_req_n = 0, w_n = 0, w_done_n = 0;
  bit w_pend = 1'b0;
  logic [AW-1:0] w_pend_addr;
  logic [AW-1:0] w_req_a [64];
  logic [DW-1:0] w_act_d [64];
  logic          w_act_l [64];

  always @(negedge clk) begin
    rw.ry = 1'b0;
    if (w_pend) begin
      rw.ry        = 1'b1;
      rw.read_data = sram[w_pend_addr];
      w_pend       = 1'b0;
    end
    if (rw.cs_n === 1'b0) begin
      w_req_a[w_req_n % 64] = rw.address;
      w_req_n++;
      w_pend      = 1'b1;
      w_pend_addr = rw.address;
    end
    if (!rst && rw.out_valid && rw.out_ready) begin
      w_act_d[w_n % 64] = rw.out_data;
      w_act_l[w_n % 64] = rw.out_last;
      w_n++;
    end
    if (w_done) w_done_n++;
  end

  typedef struct {
    int lat;
    int pct;
    int hold;
    bit noise;
    int restart_at;
    bit rand_data;
    bit bp_check;
    int exp_words;
    int exp_min;
  } case_t;

  case_t cases [10];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_case(input int idx);
    case_t c;
    int a0, d0, r0, h0, o0, w0, g0, b0, ov0, t0;
    bit rs, hc, got;
    logic [DW-1:0] sum;
    logic [DW-1:0] ed [NW];
    c = cases[idx];
    if (c.rand_data) for (int i = 0; i < NW; i++) sram[i] = $urandom;
    sum = '0;
    for (int i = 0; i < NW; i++) begin
      ed[i] = sram[i];
      sum   = sum + ed[i];
    end
    lat_cfg = c.lat; ready_pct = c.pct; noise_en = c.noise;
    a0 = act_n; d0 = done_n; r0 = req_n; h0 = hold_err; o0 = overlap_err;
    w0 = we_err; g0 = gap_err; b0 = busy_err; ov0 = occ_over;
    hold_until = cyc + 1 + c.hold;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", busy, 1'b1);
    rs = 1'b0; hc = 1'b0; got = 1'b0;
    for (int k = 0; k < 4000 && !got; k++) begin
      if (c.restart_at > 0 && !rs && act_n - a0 >= c.restart_at) begin
        start = 1'b1;
        rs    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c.bp_check && !hc && cyc >= hold_until - 1) begin
        hc = 1'b1;
        chk("bp_requests", req_n - r0, DEPTH);
        chk("bp_occupancy", occ, DEPTH);
        chk("bp_cs_n", rr.cs_n, 1'b1);
        chk("bp_out_valid", rr.out_valid, 1'b1);
      end
      tick(1);
      if (done_n != d0) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", got, 1'b1);
    chk("min_cycles", (cyc - t0) >= c.exp_min, 1'b1);
    chk("word_count", act_n - a0, c.exp_words);
    for (int i = 0; i < NW && i < act_n - a0; i++) begin
      chk("data", act_d[(a0 + i) % QN], ed[i]);
      chk("last", act_l[(a0 + i) % QN], (i == NW - 1));
    end
    chk("first_addr", req_a[r0 % QN], 8'h00);
    chk("req_count", req_n - r0, NW);
    chk("stall_hold", hold_err - h0, 0);
    chk("one_outstanding", overlap_err - o0, 0);
    chk("we_n_high", we_err - w0, 0);
    chk("done_gap", gap_err - g0, 0);
    chk("busy_at_done", busy_err - b0, 0);
    chk("fifo_overflow", occ_over - ov0, 0);
`ifdef RESULT_READER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
    tick(4);
    chk("done_once", done_n - d0, 1);
    chk("busy_idle", busy, 1'b0);
`ifdef RESULT_READER_CHECKSUM_EN
    chk("checksum_hold", checksum, sum);
`endif
    $display("[TB] run %0d: lat=%0d pct=%0d words=%0d cycles=%0d", idx, c.lat, c.pct, act_n - a0, cyc - t0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cs_n"}, rr.cs_n, 1'b1);
    chk({tag, "_we_n"}, rr.we_n, 1'b1);
    chk({tag, "_address"}, rr.address, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_out_valid"}, rr.out_valid, 1'b0);
    chk({tag, "_out_last"}, rr.out_last, 1'b0);
    chk({tag, "_out_data"}, rr.out_data, 32'h0);
  endtask

  initial begin
    int a0, d0, r0, wr0, wd0, wn0;
    bit got;
    logic [DW-1:0] wsum;
    rst = 1'b1; start = 1'b0; w_start = 1'b0;
    rw.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) sram[i] = 32'h1000 + i;

    // lat, pct, hold, noise, restart_at, rand_data, bp_check, exp_words, exp_min
    cases[0] = '{1, 100,  0, 1'b0, 0, 1'b0, 1'b0, NW, NW * 2};
    cases[1] = '{1, 100, 20, 1'b0, 0, 1'b0, 1'b1, NW, NW * 2};
    cases[2] = '{3, 100,  0, 1'b0, 0, 1'b0, 1'b0, NW, NW * 4};
    cases[3] = '{1, 100,  0, 1'b0, 5, 1'b0, 1'b0, NW, NW * 2};
    for (int i = 4; i < 10; i++) begin
      cases[i].lat        = 1 + int'($urandom_range(3));
      cases[i].pct        = 30 + int'($urandom_range(70));
      cases[i].hold       = int'($urandom_range(10));
      cases[i].noise      = 1'b1;
      cases[i].restart_at = (i % 2 == 0) ? 1 + int'($urandom_range(NW - 2)) : 0;
      cases[i].rand_data  = 1'b1;
      cases[i].bp_check   = 1'b0;
      cases[i].exp_words  = NW;
      cases[i].exp_min    = NW * (cases[i].lat + 1);
    end

    tick(3);
    check_reset_values("reset");
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 4; i++) run_case(i);

    // Reset partway through a run: no done, outputs back to reset values, next run starts over.
    lat_cfg = 1; ready_pct = 100; noise_en = 1'b0; hold_until = 0;
    a0 = act_n; d0 = done_n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      tick(1);
      if (act_n - a0 >= 7) got = 1'b1;
    end
    chk("reach_word7", got, 1'b1);
    rst = 1'b1;
    tick(1);
    check_reset_values("midrun_rst");
    rst = 1'b0;
    flush_gen++;
    tick(40);
    chk("no_done_after_rst", done_n - d0, 0);
    chk("idle_after_rst", busy, 1'b0);
    run_case(0);

    for (int i = 4; i < 10; i++) run_case(i);

    // Address wrap: BASE_ADDR=FE, four words.
    wr0 = w_req_n; wd0 = w_done_n; wn0 = w_n;
    wsum = '0;
    for (int i = 0; i < 4; i++) wsum = wsum + sram[(8'hFE + i) % 256];
    w_start = 1'b1;
    tick(1);
    w_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      tick(1);
      if (w_done_n != wd0) got = 1'b1;
    end
    chk("wrap_done", got, 1'b1);
    chk("wrap_words", w_n - wn0, 4);
    chk("wrap_reqs", w_req_n - wr0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", w_req_a[(wr0 + i) % 64], (8'hFE + i) % 256);
      chk("wrap_data", w_act_d[(wn0 + i) % 64], sram[(8'hFE + i) % 256]);
      chk("wrap_last", w_act_l[(wn0 + i) % 64], (i == 3));
    end
`ifdef RESULT_READER_CHECKSUM_EN
    chk("wrap_checksum", w_checksum, wsum);
`endif
    $display("[TB] wrap run: words=%0d sum=0x%08h", w_n - wn0, wsum);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests run, expected completion", tests);
    $fatal(1, "watchdog");
  end

endmodule
